// File: rtl/fnmadd_norm_ctrl.sv
// fnmadd_norm_ctrl: multi-cycle normalization controller for the FNMADD datapath.
// Registers the aligned addends, feeds them to an external LZA, normalizes the
// sum by the anticipated count, applies the one-bit LZA correction and adjusts
// the exponent. Valid/ready handshakes on both sides; fixed 3-cycle latency.
module fnmadd_norm_ctrl #(
  parameter  int SIG_WIDTH = 23,
  parameter  int EXP_WIDTH = 10,
  localparam int W         = 2 * (SIG_WIDTH + 1) + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_op_a,
  input  logic [W-1:0]         in_op_b,
  input  logic [EXP_WIDTH-1:0] in_exp,
  input  logic                 flush,
  output logic [W-1:0]         lza_op_a,
  output logic [W-1:0]         lza_op_b,
  input  logic [5:0]           lza_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_sig,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic                 out_zero,
  output logic                 out_corr,
  output logic                 out_uflow
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LZA   = 3'd1,
    SHIFT = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         op_a_q, op_a_d;
  logic [W-1:0]         op_b_q, op_b_d;
  logic [EXP_WIDTH-1:0] exp_in_q, exp_in_d;
  logic [W-1:0]         sum_q, sum_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [W-1:0]         sig_q, sig_d;
  logic                 zero_q, zero_d;
  logic                 corr_q, corr_d;
  logic                 uflow_q, uflow_d;
  logic [EXP_WIDTH-1:0] exp_out_q, exp_out_d;

  // Correction-stage datapath, evaluated from the SHIFT results every cycle
  logic                 need_corr;
  logic [W-1:0]         sig_fix;
  logic [6:0]           total_shift;
  logic [EXP_WIDTH:0]   exp_wide;

  // One-bit LZA correction and exponent subtraction with sign in the extra bit
  always_comb begin
    need_corr   = !zero_q && !sig_q[W-1];
    sig_fix     = need_corr ? (sig_q << 1) : sig_q;
    total_shift = {1'b0, cnt_q} + {6'd0, need_corr};
    exp_wide    = {1'b0, exp_in_q} - (EXP_WIDTH + 1)'(total_shift);
  end

  // Next-state and next-output computation for the controller
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    exp_in_d    = exp_in_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    sig_d       = sig_q;
    zero_d      = zero_q;
    corr_d      = corr_q;
    uflow_d     = uflow_q;
    exp_out_d   = exp_out_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d     = in_op_a;
          op_b_d     = in_op_b;
          exp_in_d   = in_exp;
          zero_d     = 1'b0;
          corr_d     = 1'b0;
          uflow_d    = 1'b0;
          in_ready_d = 1'b0;
          state_d    = LZA;
        end
      end
      LZA: begin
        sum_d   = op_a_q + op_b_q;
        cnt_d   = lza_count;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (sum_q == '0) begin
          zero_d = 1'b1;
          sig_d  = '0;
        end else begin
          sig_d  = sum_q << cnt_q;
        end
        state_d = FIX;
      end
      FIX: begin
        sig_d = sig_fix;
        if (zero_q) begin
          exp_out_d = '0;
          uflow_d   = 1'b0;
          corr_d    = 1'b0;
        end else begin
          corr_d = need_corr;
          if (exp_wide[EXP_WIDTH]) begin
            exp_out_d = '0;
            uflow_d   = 1'b1;
          end else begin
            exp_out_d = exp_wide[EXP_WIDTH-1:0];
            uflow_d   = 1'b0;
          end
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase

    // Abort overrides the handshake; idle state has nothing to drop
    if (flush && (state_q != IDLE)) begin
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      state_d     = IDLE;
    end
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      exp_in_q    <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      sig_q       <= '0;
      zero_q      <= 1'b0;
      corr_q      <= 1'b0;
      uflow_q     <= 1'b0;
      exp_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      exp_in_q    <= exp_in_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      zero_q      <= zero_d;
      corr_q      <= corr_d;
      uflow_q     <= uflow_d;
      exp_out_q   <= exp_out_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign lza_op_a  = op_a_q;
  assign lza_op_b  = op_b_q;
  assign out_sig   = sig_q;
  assign out_exp   = exp_out_q;
  assign out_zero  = zero_q;
  assign out_corr  = corr_q;
  assign out_uflow = uflow_q;

endmodule

// File: tb/tb_fnmadd_norm_ctrl.sv
// Directed bench for fnmadd_norm_ctrl with a behavioural LZA that can be told
// to under-estimate by one, forcing the correction path.
module tb_fnmadd_norm_ctrl;

  localparam int W = 50;
  localparam int E = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_op_a = '0;
  logic [W-1:0] in_op_b = '0;
  logic [E-1:0] in_exp = '0;
  logic         flush = 1'b0;
  logic [W-1:0] lza_op_a, lza_op_b;
  logic [5:0]   lza_count;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sig;
  logic [E-1:0] out_exp;
  logic         out_zero, out_corr, out_uflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic         lza_under = 1'b0;
  logic [W-1:0] lza_sum;
  int           lza_n;

  fnmadd_norm_ctrl #(.SIG_WIDTH(23), .EXP_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_exp(in_exp), .flush(flush),
    .lza_op_a(lza_op_a), .lza_op_b(lza_op_b), .lza_count(lza_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_sig(out_sig),
    .out_exp(out_exp), .out_zero(out_zero), .out_corr(out_corr),
    .out_uflow(out_uflow)
  );

  always #5 clk = ~clk;

  function automatic int lzc(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) return W - 1 - i;
    end
    return W;
  endfunction

  function automatic logic [W-1:0] bit_at(input int k);
    logic [W-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  // Behavioural LZA: exact leading-zero count, optionally one short
  always_comb begin
    lza_sum = lza_op_a + lza_op_b;
    lza_n   = lzc(lza_sum);
    if (lza_under && lza_n > 0) lza_n = lza_n - 1;
    lza_count = 6'(lza_n);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set and return just after the accept edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [E-1:0] e, input logic under);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      n_fail++;
      $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
    end
    lza_under = under;
    in_op_a   = a;
    in_op_b   = b;
    in_exp    = e;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({in_ready, out_valid, out_zero, out_corr, out_uflow} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 10000",
               {in_ready, out_valid, out_zero, out_corr, out_uflow});
    end
    n_checks++;
    if ({out_sig, out_exp, lza_op_a, lza_op_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: sig=%h exp=%0d lza_a=%h lza_b=%h required all 0",
               out_sig, out_exp, lza_op_a, lza_op_b);
    end
  endtask

  task automatic test_basic();
    issue(bit_at(47), bit_at(47), 10'd100, 1'b0);
    n_checks++;
    if ({in_ready, lza_op_a, lza_op_b} !== {1'b0, bit_at(47), bit_at(47)}) begin
      n_fail++;
      $display("FAIL basic_lza_ops: ready=%b a=%h b=%h required 0 %h %h",
               in_ready, lza_op_a, lza_op_b, bit_at(47), bit_at(47));
    end
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid: out_valid=%b required 0 at cycle 2", out_valid);
    end
    tick();
    n_checks++;
    if ({out_valid, out_zero, out_corr, out_uflow, out_exp} !== {4'b1000, 10'd99}) begin
      n_fail++;
      $display("FAIL basic_result: v/z/c/u=%b exp=%0d required 1000 99",
               {out_valid, out_zero, out_corr, out_uflow}, out_exp);
    end
    n_checks++;
    if (out_sig !== bit_at(49)) begin
      n_fail++;
      $display("FAIL basic_sig: got %h required %h", out_sig, bit_at(49));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_release: ready/valid=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_correction();
    issue(bit_at(0), '0, 10'd100, 1'b1);
    repeat (3) tick();
    n_checks++;
    if ({out_valid, out_zero, out_corr, out_uflow, out_exp, out_sig}
        !== {4'b1010, 10'd51, bit_at(49)}) begin
      n_fail++;
      $display("FAIL corr_result: v/z/c/u=%b exp=%0d sig=%h required 1010 51 %h",
               {out_valid, out_zero, out_corr, out_uflow}, out_exp, out_sig, bit_at(49));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_underflow();
    issue(bit_at(0), '0, 10'd20, 1'b1);
    repeat (3) tick();
    n_checks++;
    if ({out_valid, out_zero, out_corr, out_uflow, out_exp, out_sig}
        !== {4'b1011, 10'd0, bit_at(49)}) begin
      n_fail++;
      $display("FAIL uflow_result: v/z/c/u=%b exp=%0d sig=%h required 1011 0 %h",
               {out_valid, out_zero, out_corr, out_uflow}, out_exp, out_sig, bit_at(49));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_zero();
    logic [W-1:0] neg5;
    neg5 = '0;
    neg5 = neg5 - 5;
    issue(50'd5, neg5, 10'd77, 1'b0);
    repeat (3) tick();
    n_checks++;
    if ({out_valid, out_zero, out_corr, out_uflow, out_exp, out_sig}
        !== {4'b1100, 10'd0, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL zero_result: v/z/c/u=%b exp=%0d sig=%h required 1100 0 0",
               {out_valid, out_zero, out_corr, out_uflow}, out_exp, out_sig);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    issue(bit_at(47), bit_at(47), 10'd100, 1'b0);
    repeat (3) tick();
    // Hold in DONE with a competing request on the input side
    in_op_a  = bit_at(3);
    in_op_b  = '0;
    in_exp   = 10'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({out_valid, in_ready, out_sig, out_exp, out_corr}
          !== {2'b10, bit_at(49), 10'd99, 1'b0}) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release: ready/valid=%b required 10", {in_ready, out_valid});
    end
    // Immediate second op: sum 2^21 -> 28 leading zeros, exponent 200-28
    out_ready = 1'b1;
    issue(bit_at(20), bit_at(20), 10'd200, 1'b0);
    repeat (3) tick();
    n_checks++;
    if ({out_valid, out_zero, out_corr, out_uflow, out_exp, out_sig}
        !== {4'b1000, 10'd172, bit_at(49)}) begin
      n_fail++;
      $display("FAIL b2b_result: v/z/c/u=%b exp=%0d sig=%h required 1000 172 %h",
               {out_valid, out_zero, out_corr, out_uflow}, out_exp, out_sig, bit_at(49));
    end
    tick();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_release: ready/valid=%b required 10", {in_ready, out_valid});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_reset();
    int seen = 0;
    issue(bit_at(0), '0, 10'd100, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_idle: ready/valid=%b required 10", {in_ready, out_valid});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_no_result: %0d valid cycles, required 0", seen);
    end
    issue(bit_at(0), '0, 10'd100, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_async: ready/valid=%b required 10", {in_ready, out_valid});
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_no_result: %0d valid cycles, required 0", seen);
    end
    issue(bit_at(47), bit_at(47), 10'd100, 1'b0);
    repeat (3) tick();
    n_checks++;
    if ({out_valid, out_zero, out_corr, out_uflow, out_exp, out_sig}
        !== {4'b1000, 10'd99, bit_at(49)}) begin
      n_fail++;
      $display("FAIL after_rst_result: v/z/c/u=%b exp=%0d sig=%h required 1000 99 %h",
               {out_valid, out_zero, out_corr, out_uflow}, out_exp, out_sig, bit_at(49));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #23;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_correction();
    test_underflow();
    test_zero();
    test_back_to_back();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
